// File: rtl/cfu_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : cfu_resolve_unit
// Brief    : Execute-stage branch/jump resolution with registered redirect,
//            two-cycle front-end flush, 2-bit BHT and event counters.
// Revision : 1.0 - initial release
// ============================================================================
module cfu_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic            stall_i,
    input  logic [3:0]      ex_cfuop_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    input  logic [XLEN-1:0] ex_rs2_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    output logic [XLEN-1:0] link_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispredict_cnt_o
);

    localparam int IDXW = $clog2(BHT_ENTRIES);

    localparam logic [3:0] c_OP_BEQ  = 4'd1;
    localparam logic [3:0] c_OP_BNE  = 4'd2;
    localparam logic [3:0] c_OP_BLT  = 4'd3;
    localparam logic [3:0] c_OP_BGE  = 4'd4;
    localparam logic [3:0] c_OP_BLTU = 4'd5;
    localparam logic [3:0] c_OP_BGEU = 4'd6;
    localparam logic [3:0] c_OP_JAL  = 4'd7;
    localparam logic [3:0] c_OP_JALR = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_SQUASH   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_bht [BHT_ENTRIES];
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_branch_cnt;
    logic [31:0]     r_mispredict_cnt;

    logic [XLEN-1:0] w_link;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_correct_pc;
    logic            w_taken;
    logic            w_is_cond;
    logic            w_is_jump;
    logic            w_eval;
    logic            w_mispredict;
    logic [IDXW-1:0] w_ex_idx;
    logic [IDXW-1:0] w_if_idx;
    logic [1:0]      w_ex_ctr;
    logic            w_unused;

    assign w_link      = ex_pc_i + XLEN'(4);
    assign w_br_target = ex_pc_i + ex_imm_i;
    assign w_jalr_sum  = ex_rs1_i + ex_imm_i;
    assign w_ex_idx    = ex_pc_i[IDXW+1:2];
    assign w_if_idx    = if_pc_i[IDXW+1:2];
    assign w_ex_ctr    = r_bht[w_ex_idx];
    assign w_unused    = &{1'b0, ex_pc_i[1:0], if_pc_i[1:0], w_jalr_sum[0]};

    always_comb begin
        w_taken   = 1'b0;
        w_is_cond = 1'b0;
        w_is_jump = 1'b0;
        w_target  = w_br_target;
        case (ex_cfuop_i)
            c_OP_BEQ:  begin w_is_cond = 1'b1; w_taken = (ex_rs1_i == ex_rs2_i); end
            c_OP_BNE:  begin w_is_cond = 1'b1; w_taken = (ex_rs1_i != ex_rs2_i); end
            c_OP_BLT:  begin w_is_cond = 1'b1; w_taken = ($signed(ex_rs1_i) <  $signed(ex_rs2_i)); end
            c_OP_BGE:  begin w_is_cond = 1'b1; w_taken = ($signed(ex_rs1_i) >= $signed(ex_rs2_i)); end
            c_OP_BLTU: begin w_is_cond = 1'b1; w_taken = (ex_rs1_i <  ex_rs2_i); end
            c_OP_BGEU: begin w_is_cond = 1'b1; w_taken = (ex_rs1_i >= ex_rs2_i); end
            c_OP_JAL:  begin w_is_jump = 1'b1; w_taken = 1'b1; end
            c_OP_JALR: begin
                w_is_jump = 1'b1;
                w_taken   = 1'b1;
                w_target  = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_eval       = (r_state == S_IDLE) && ex_valid_i && !stall_i;
    assign w_mispredict = (w_taken != ex_pred_taken_i) ||
                          (w_taken && (w_target != ex_pred_target_i));
    assign w_correct_pc = w_taken ? w_target : w_link;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_eval && w_mispredict) w_state_next = S_REDIRECT;
            S_REDIRECT: w_state_next = S_SQUASH;
            S_SQUASH:   w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_pc    <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_eval) begin
            if (w_mispredict) begin
                r_redirect_pc    <= w_correct_pc;
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
            if (w_is_cond || w_is_jump) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
        end
    end

    // Saturating 2-bit counters; only conditional branches train the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_eval && w_is_cond) begin
            if (w_taken) begin
                if (w_ex_ctr != 2'b11) r_bht[w_ex_idx] <= w_ex_ctr + 2'd1;
            end else begin
                if (w_ex_ctr != 2'b00) r_bht[w_ex_idx] <= w_ex_ctr - 2'd1;
            end
        end
    end

    assign if_pred_taken_o  = r_bht[w_if_idx][1];
    assign link_o           = w_link;
    assign redirect_o       = (r_state == S_REDIRECT);
    assign flush_o          = (r_state != S_IDLE);
    assign redirect_pc_o    = r_redirect_pc;
    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;

endmodule
`default_nettype wire
